baseline_tracker: RTL
=====================

# baseline_tracker

Parametrised successor to the first-generation baseline calculator in the minimum-trigger front end. It averages ADC samples from the RF Data Converter AXI4-Stream over an exact power-of-two window, with no recursive-halving error, and supports signed or unsigned samples. On request it re-runs the calculation while holding the previous baseline, and it publishes the baseline together with a saturated trigger threshold for the downstream trigger comparator.

## Interface
Parameters:
- ADC_RESOLUTION_WIDTH, 12: valid bits per sample (LSB-aligned in each lane).
- SAMPLE_WIDTH, 16: lane stride in TDATA.
- S_AXIS_TDATA_WIDTH, 128: bus width. LANES = S_AXIS_TDATA_WIDTH/SAMPLE_WIDTH must be a power of two.
- LOG2_CALC_BEATS, 10: window length is 2^LOG2_CALC_BEATS accepted beats.
- THRESHOLD_OFFSET, 410: added to the baseline to form O_THRESHOLD.
- SIGNED_SAMPLES, 1: 1 means two's-complement samples, 0 means unsigned.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  reset. One clock; reset is synchronous and active-low.
- EXEC_STATE  in  2  system state: 2'b00 INIT, 2'b11 TRG.
- RECALC  in  1  single-cycle request for a new calculation.
- S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  sample lanes.
- S_AXIS_TVALID  in  1  beat valid. The block never back-pressures; it has no TREADY.
- O_BASELINE  out  ADC_RESOLUTION_WIDTH  latched average.
- O_THRESHOLD  out  ADC_RESOLUTION_WIDTH  saturated baseline + THRESHOLD_OFFSET.
- O_CALC_COMPLETE  out  1  sticky: high once the first window completes.
- O_BASELINE_UPDATE  out  1  one-cycle pulse when O_BASELINE/O_THRESHOLD change.
- O_BUSY  out  1  high in ACCUM or FLUSH.

## Operation
- Lane i is TDATA[SAMPLE_WIDTH*i +: ADC_RESOLUTION_WIDTH], sign- or zero-extended according to SIGNED_SAMPLES.
- A beat is accepted when S_AXIS_TVALID=1 and EXEC_STATE=INIT while in ACCUM.
- Stage 1 (lane_sum_tree): registered sum of all lanes, width ADC_RESOLUTION_WIDTH+log2(LANES), with a sum_valid flag.
- Stage 2: accumulator of width ADC_RESOLUTION_WIDTH+log2(LANES)+LOG2_CALC_BEATS; it adds the stage-1 sum whenever sum_valid=1.
- Result = accumulator arithmetic-shifted right by log2(LANES)+LOG2_CALC_BEATS. Signed results round toward negative infinity; unsigned results truncate.
- Threshold = result + THRESHOLD_OFFSET, clamped to 2^(W-1)-1 when signed or 2^W-1 when unsigned, with W = ADC_RESOLUTION_WIDTH.
- State machine:
  - IDLE → ACCUM when EXEC_STATE=INIT. The accumulator and beat counter are cleared on entry.
  - ACCUM → FLUSH on the 2^LOG2_CALC_BEATS-th accepted beat.
  - ACCUM → IDLE (abort) if EXEC_STATE≠INIT. The partial sum is discarded and the outputs are unchanged.
  - FLUSH → DONE once sum_valid=0. The result is latched, O_BASELINE_UPDATE pulses and O_CALC_COMPLETE is set.
  - DONE → ACCUM on RECALC=1 with EXEC_STATE=INIT. RECALC is ignored in every other state or condition.
- TVALID gaps in ACCUM stall counting only; they are not an error.
- During recalculation O_BASELINE, O_THRESHOLD and O_CALC_COMPLETE hold their old values until the new latch.

## Timing
- Reset values: O_BASELINE=0, O_THRESHOLD=0, O_CALC_COMPLETE=0, O_BASELINE_UPDATE=0, O_BUSY=0; state IDLE, accumulator 0, counter 0, sum_valid 0.
- Latency, with edge t being the acceptance of the last window beat:
  - Stage-1 sum registered at t+1.
  - Accumulator complete at t+2.
  - O_BASELINE, O_THRESHOLD and the O_BASELINE_UPDATE pulse registered at t+3.
  - O_CALC_COMPLETE rises at t+3 on the first window.
- O_BUSY rises one cycle after the IDLE→ACCUM or DONE→ACCUM transition condition. It falls in the same cycle as O_BASELINE_UPDATE.
- Abort during FLUSH is not possible: FLUSH ignores EXEC_STATE so that the window completes.
- Reset asserted mid-window returns everything to reset values on the next edge. O_CALC_COMPLETE is cleared.
- Beat counter width is LOG2_CALC_BEATS+1. It cannot wrap because it is cleared on every ACCUM entry.

## Structure
- Shared package trigger_pkg holds:
  - EXEC_STATE encodings (INIT=2'b00, TRG=2'b11).
  - The clogb2 function.
  - The FSM state typedef (IDLE, ACCUM, FLUSH, DONE).
- Sub-module lane_sum_tree(LANES, ADC_RESOLUTION_WIDTH, SAMPLE_WIDTH, SIGNED_SAMPLES) holds lane extraction, the registered sum and sum_valid.
- The top level holds the FSM, counter, accumulator, shift, saturation and output registers.

## Test plan
- **Constant level:** LOG2_CALC_BEATS=2, all lanes 100, TVALID held high, EXEC_STATE=INIT → O_BASELINE=100, O_THRESHOLD=510, O_CALC_COMPLETE=1 and one O_BASELINE_UPDATE pulse at 3 cycles after the 4th beat.
- **Signed rounding:** lanes alternate -3/-4 → O_BASELINE=-4. Unsigned build with lanes alternating 3/4 → O_BASELINE=3.
- **TVALID gaps:** 4 valid beats spread over 11 cycles → same result as the gap-free case; O_BUSY is high throughout.
- **Abort:** EXEC_STATE→TRG after 2 beats → O_BUSY falls, O_CALC_COMPLETE stays 0, O_BASELINE stays 0. Returning to INIT restarts and completes normally.
- **Recalculation and saturation:**
  - First baseline 2000 → O_THRESHOLD=2047.
  - RECALC followed by data at 50 → outputs hold 2000/2047 until the update pulse, then become 50/460.
  - RECALC asserted while in ACCUM is ignored.
- **Reset mid-window:** AXIS_ARESETN=0 for 1 cycle after the 3rd beat → all outputs 0. The next full window yields the correct baseline.

Source files
------------

// File: rtl/trigger_pkg.sv
// trigger_pkg: shared encodings, FSM state type and clogb2 for the trigger front end
package trigger_pkg;
    localparam logic [1:0] EXEC_INIT = 2'b00;
    localparam logic [1:0] EXEC_TRG  = 2'b11;
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/lane_sum_tree.sv
// lane_sum_tree: registers an accepted beat, then registers the extended sum of its lanes
module lane_sum_tree
    import trigger_pkg::*;
#(
    parameter int LANES                = 8,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int SIGNED_SAMPLES       = 1,
    localparam int SUM_W = ADC_RESOLUTION_WIDTH + clogb2(LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*SAMPLE_WIDTH-1:0] tdata_i,
    input  logic                          valid_i,
    output logic [SUM_W-1:0]              sum_o,
    output logic                          sum_valid_o,
    output logic                          pending_o
);
    localparam int W = ADC_RESOLUTION_WIDTH;
    logic [LANES*SAMPLE_WIDTH-1:0] data_q;
    logic                          valid_q, sum_valid_q;
    logic [SUM_W-1:0]              sum_d, sum_q;
    logic [W-1:0]                  lane;
    always_comb begin
        sum_d = '0;
        lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane  = data_q[SAMPLE_WIDTH*i +: W];
            sum_d = sum_d + {{(SUM_W-W){SIGNED_SAMPLES != 0 && lane[W-1]}}, lane};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            data_q      <= tdata_i;
            valid_q     <= valid_i;
            sum_q       <= sum_d;
            sum_valid_q <= valid_q;
        end
    end
    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign pending_o   = valid_q | sum_valid_q;
endmodule

// File: rtl/baseline_tracker.sv
// baseline_tracker: exact power-of-two window average of ADC lanes with saturated trigger threshold
module baseline_tracker
    import trigger_pkg::*;
#(
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int LOG2_CALC_BEATS      = 10,
    parameter int THRESHOLD_OFFSET     = 410,
    parameter int SIGNED_SAMPLES       = 1
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic [1:0]                      EXEC_STATE,
    input  logic                            RECALC,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    output logic [ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
    output logic [ADC_RESOLUTION_WIDTH-1:0] O_THRESHOLD,
    output logic                            O_CALC_COMPLETE,
    output logic                            O_BASELINE_UPDATE,
    output logic                            O_BUSY
);
    localparam int W       = ADC_RESOLUTION_WIDTH;
    localparam int LANES   = S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int SUM_W   = W + clogb2(LANES);
    localparam int ACC_W   = SUM_W + LOG2_CALC_BEATS;
    localparam int CNT_W   = LOG2_CALC_BEATS + 1;
    localparam int THR_MAX = SIGNED_SAMPLES != 0 ? (1 << (W - 1)) - 1 : (1 << W) - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_CALC_BEATS) - 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum_ext;
    logic [W-1:0]      base_q, base_d, thr_q, thr_d, result;
    logic              upd_q, cmp_q, cmp_d;
    logic [SUM_W-1:0]  sum;
    logic              sum_valid, pending, init, accept, start, latch;
    logic signed [31:0] res_ext, thr_wide;
    lane_sum_tree #(
        .LANES(LANES), .ADC_RESOLUTION_WIDTH(W),
        .SAMPLE_WIDTH(SAMPLE_WIDTH), .SIGNED_SAMPLES(SIGNED_SAMPLES)
    ) u_sum (
        .clk(AXIS_ACLK), .rst_n(AXIS_ARESETN), .tdata_i(S_AXIS_TDATA), .valid_i(accept),
        .sum_o(sum), .sum_valid_o(sum_valid), .pending_o(pending)
    );
    assign init   = EXEC_STATE == EXEC_INIT;
    assign accept = state_q == ACCUM && init && S_AXIS_TVALID;
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) state_q <= IDLE;
        else               state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = init ? ACCUM : IDLE;
            ACCUM:   state_d = !init ? IDLE : (accept && cnt_q == LAST_CNT) ? FLUSH : ACCUM;
            FLUSH:   state_d = pending ? FLUSH : DONE;
            DONE:    state_d = (init && RECALC) ? ACCUM : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        start  = state_d == ACCUM && state_q != ACCUM;
        latch  = state_q == FLUSH && state_d == DONE;
        O_BUSY = state_q inside {ACCUM, FLUSH};
    end
    // The top W bits of the accumulator are the shift by log2(LANES)+LOG2_CALC_BEATS: floor when signed.
    assign sum_ext  = {{LOG2_CALC_BEATS{SIGNED_SAMPLES != 0 && sum[SUM_W-1]}}, sum};
    assign result   = acc_q[ACC_W-1 -: W];
    assign res_ext  = SIGNED_SAMPLES != 0 ? {{(32-W){result[W-1]}}, result} : {{(32-W){1'b0}}, result};
    assign thr_wide = res_ext + THRESHOLD_OFFSET;
    always_comb begin
        cnt_d  = start ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
        acc_d  = start ? '0 : sum_valid ? acc_q + sum_ext : acc_q;
        base_d = latch ? result : base_q;
        thr_d  = !latch ? thr_q : (thr_wide > THR_MAX) ? W'(THR_MAX) : thr_wide[W-1:0];
        cmp_d  = cmp_q | latch;
    end
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            base_q <= '0;
            thr_q  <= '0;
            upd_q  <= 1'b0;
            cmp_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            base_q <= base_d;
            thr_q  <= thr_d;
            upd_q  <= latch;
            cmp_q  <= cmp_d;
        end
    end
    assign O_BASELINE        = base_q;
    assign O_THRESHOLD       = thr_q;
    assign O_BASELINE_UPDATE = upd_q;
    assign O_CALC_COMPLETE   = cmp_q;
endmodule
